// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and shared types for the 800x600@60 Hz display
// path (40 MHz pixel clock).
//   HOR_* / VER_*     visible, front porch, sync width and total per axis
//   *_SYNC_START/END  derived sync window, END is exclusive
//   cnt_t / rgb_t     field types of the vga_if stream
//   in_window()       half-open range test used for sync decode
package vga_pkg;

  localparam int unsigned HOR_VISIBLE = 800;
  localparam int unsigned HOR_FP      = 40;
  localparam int unsigned HOR_SYNC    = 128;
  localparam int unsigned HOR_TOTAL   = 1056;

  localparam int unsigned VER_VISIBLE = 600;
  localparam int unsigned VER_FP      = 1;
  localparam int unsigned VER_SYNC    = 4;
  localparam int unsigned VER_TOTAL   = 628;

  localparam int unsigned HOR_SYNC_START = HOR_VISIBLE + HOR_FP;
  localparam int unsigned HOR_SYNC_END   = HOR_SYNC_START + HOR_SYNC;
  localparam int unsigned VER_SYNC_START = VER_VISIBLE + VER_FP;
  localparam int unsigned VER_SYNC_END   = VER_SYNC_START + VER_SYNC;

  localparam int unsigned CNT_W       = 11;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // True when lo <= val < hi.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: pixel stream passed between display stages.
//   hcount/vcount  current pixel position
//   hsync/vsync    active-high sync
//   hblnk/vblnk    blanking flags
//   rgb            pixel colour
//   modport out    producer side, modport in consumer side
interface vga_if;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  rgb_t rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source of the vga_if stream. Generates pixel/line counters,
// blanking and sync, plus a per-frame tick and a completed-frame counter.
// rgb is driven black; later stages paint pixels.
//   clk         pixel clock (single clock domain)
//   rst         asynchronous, active-low reset
//   en          count enable; when low every output holds, frame_tick reads 0
//   vga_out     vga_if producer modport
//   frame_tick  one-cycle pulse on the cycle presenting (0,0) after a wrap
//   frame_cnt   completed frames, wraps at 16 bits
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = HOR_VISIBLE,
  parameter int unsigned H_FP      = HOR_FP,
  parameter int unsigned H_SYNC    = HOR_SYNC,
  parameter int unsigned H_TOTAL   = HOR_TOTAL,
  parameter int unsigned V_VISIBLE = VER_VISIBLE,
  parameter int unsigned V_FP      = VER_FP,
  parameter int unsigned V_SYNC    = VER_SYNC,
  parameter int unsigned V_TOTAL   = VER_TOTAL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  vga_if.out                     vga_out,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t H_SYNC_S = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t H_SYNC_E = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam cnt_t V_SYNC_S = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t V_SYNC_E = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

  cnt_t h_q, v_q;
  logic hsync_q, vsync_q, hblnk_q, vblnk_q;

  cnt_t                   h_nxt, v_nxt;
  logic                   hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;
  logic                   wrap_frame;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

  // Next position plus decode of that position, so the flopped flags line up
  // with the flopped counts in the same cycle. Out-of-range counts (>= last)
  // fall back to 0; only an exact (H_LAST, V_LAST) counts as a frame wrap.
  always_comb begin
    h_nxt      = h_q + cnt_t'(1);
    v_nxt      = v_q;
    wrap_frame = 1'b0;

    if (h_q >= H_LAST) begin
      h_nxt      = '0;
      v_nxt      = (v_q >= V_LAST) ? '0 : v_q + cnt_t'(1);
      wrap_frame = (h_q == H_LAST) && (v_q == V_LAST);
    end else if (v_q > V_LAST) begin
      v_nxt = '0;
    end

    hblnk_nxt     = (h_nxt >= H_VIS);
    vblnk_nxt     = (v_nxt >= V_VIS);
    hsync_nxt     = in_window(h_nxt, H_SYNC_S, H_SYNC_E);
    vsync_nxt     = in_window(v_nxt, V_SYNC_S, V_SYNC_E);
    frame_cnt_nxt = wrap_frame ? frame_cnt + FRAME_CNT_W'(1) : frame_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblnk_q    <= 1'b0;
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else if (en) begin
      h_q        <= h_nxt;
      v_q        <= v_nxt;
      hsync_q    <= hsync_nxt;
      vsync_q    <= vsync_nxt;
      hblnk_q    <= hblnk_nxt;
      vblnk_q    <= vblnk_nxt;
      frame_tick <= wrap_frame;
      frame_cnt  <= frame_cnt_nxt;
    end else begin
      // Frozen: hold position, but never stretch the tick.
      frame_tick <= 1'b0;
    end
  end

  assign vga_out.hcount = h_q;
  assign vga_out.vcount = v_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Reduced raster so several full frames fit in a short run.
  localparam int unsigned HV  = 16;
  localparam int unsigned HFP = 2;
  localparam int unsigned HS  = 4;
  localparam int unsigned HT  = 26;
  localparam int unsigned VV  = 10;
  localparam int unsigned VFP = 1;
  localparam int unsigned VS  = 2;
  localparam int unsigned VT  = 15;
  localparam int unsigned FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  vga_if vga_bus ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .vga_out   (vga_bus),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: n = enabled clocks since reset; position is n mod the
  // raster, a tick happens whenever an enabled clock lands n on a frame multiple.
  int n       = 0;
  int exp_fc  = 0;
  int exp_tk  = 0;
  int ticks   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    chk("hcount", int'(vga_bus.hcount), h);
    chk("vcount", int'(vga_bus.vcount), v);
    chk("hblnk",  int'(vga_bus.hblnk), (h >= HV) ? 1 : 0);
    chk("vblnk",  int'(vga_bus.vblnk), (v >= VV) ? 1 : 0);
    chk("hsync",  int'(vga_bus.hsync), (h >= HV + HFP && h < HV + HFP + HS) ? 1 : 0);
    chk("vsync",  int'(vga_bus.vsync), (v >= VV + VFP && v < VV + VFP + VS) ? 1 : 0);
    chk("rgb",    int'(vga_bus.rgb), 0);
    chk("frame_tick", int'(frame_tick), exp_tk);
    chk("frame_cnt",  int'(frame_cnt), exp_fc);
  endtask

  // One clock edge with the current en, then model update and full check.
  task automatic step();
    @(posedge clk);
    #1;
    if (en) begin
      n++;
      exp_tk = (n % FRAME == 0) ? 1 : 0;
      if (exp_tk == 1) begin
        exp_fc = (exp_fc + 1) % 65536;
        ticks++;
      end
    end else begin
      exp_tk = 0;
    end
    check_all();
  endtask

  // Run enabled until the model position reaches frame offset `target`.
  task automatic run_to(input string tag, input int target);
    int guard;
    guard = 0;
    en = 1'b1;
    while ((n % FRAME) != target && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    chk(tag, ((n % FRAME) == target) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b0;
    en  = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Three full frames with en held high.
    ticks = 0;
    for (int i = 0; i < 3 * int'(FRAME); i++) step();
    chk("tick_count_3frames", ticks, 3);

    // Randomly gated enable.
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      en = ($urandom_range(3) != 0);
      step();
    end

    // Freeze at the last pixel of the frame, then resume into the wrap.
    run_to("reach_frame_end", FRAME - 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    en = 1'b1;
    step();
    chk("tick_after_hold", int'(frame_tick), 1);
    chk("h_after_hold", int'(vga_bus.hcount), 0);

    // Asynchronous reset mid-frame, between edges.
    run_to("reach_mid_frame", 8 * HT + 12);
    #2;
    rst = 1'b0;
    #1;
    n = 0; exp_fc = 0; exp_tk = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("fc_after_reset", int'(frame_cnt), 0);

    // Counter wrap from all-ones.
    run_to("reach_preload_point", FRAME - 5);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_fc = 16'hFFFF;
    for (int i = 0; i < 5; i++) step();
    chk("fc_wrap", int'(frame_cnt), 0);
    chk("tick_on_wrap", int'(frame_tick), 1);
    for (int i = 0; i < 30; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
